sbox_arbiter: RTL and testbench
===============================

SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 Parameter: PRIO0, default 0, meaning: 1 = requester 0 has strict priority over the round-robin pool; 0 = pure round-robin.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  4  per-requester request strobe; bit i = requester i.
REQ-005 req_data  input  128  packed request words; requester i at [32i+31:32i].
REQ-006 req_ready  output  4  one-hot (or zero) grant, combinational from req_valid and RR pointer.
REQ-007 resp_valid  output  4  registered one-cycle pulse: result for requester i is available.
REQ-008 resp_data  output  128  per-requester result holding registers; requester i at [32i+31:32i].
REQ-009 busy  output  1  registered; 1 while any granted word has not yet produced resp_valid.

Function
REQ-010 Block SHALL share one instance of the team's registered 4-byte S-box unit (S4, one-cycle latency, no reset) among 4 requesters.
REQ-011 Transfer for requester i occurs in the cycle where req_valid[i] & req_ready[i]; at most one transfer per cycle.
REQ-012 req_ready SHALL be zero when req_valid is zero; req_ready[i] never asserts without req_valid[i].
REQ-013 Round-robin: 2-bit pointer ptr; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first valid requester wins.
REQ-014 After a grant to i, ptr <= (i+1) mod 4; with no grant, ptr unchanged.
REQ-015 PRIO0=1: req_valid[0] wins unconditionally and ptr is unchanged; otherwise the REQ-013 search applies over requesters 1-3 with ptr as given.
REQ-016 Granted word drives S4 input directly; a muxed zero word is driven when no grant.
REQ-017 Stage-1 tag register (valid bit + 2-bit id) SHALL capture the grant in the transfer cycle T.
REQ-018 In T+1, S4 output holds the substituted word; if stage-1 tag is valid, resp_data slice [id] <= S4 output and resp_valid[id] <= 1 at end of T+1.
REQ-019 Latency: resp_valid[i] asserts in cycle T+2 for one cycle only; full throughput, one result per cycle.
REQ-020 resp_data slice i SHALL hold its value until the next result for requester i; other slices untouched.
REQ-021 resp_valid is at most one-hot in any cycle.
REQ-022 Substitution is bytewise: each output byte = AES S-box(corresponding input byte), byte positions preserved.
REQ-023 busy = stage-1 tag valid; no backpressure on responses; requesters SHALL accept resp_valid unconditionally.
REQ-024 Back-to-back grants to the same requester SHALL produce consecutive resp_valid pulses in grant order.

Reset
REQ-025 While rst=1: req_ready=0, resp_valid=0, resp_data=0, busy=0, ptr=0, stage-1 tag invalid.
REQ-026 Reset mid-operation discards any in-flight word: no resp_valid in the cycle following rst deassertion for words granted before or during rst.
REQ-027 First grant is possible in the first cycle with rst=0.
REQ-028 S4 contents are not reset; outputs SHALL never expose S4 data not tagged valid.

Verification
REQ-029 Reset: rst=1 two cycles with all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0, busy=0 throughout.
REQ-030 Single: req_valid=4'b0100, req_data[95:64]=32'h00010253 at T -> req_ready=4'b0100 at T, busy=1 at T+1, resp_valid=4'b0100 at T+2, resp_data[95:64]=32'h637c77ed held thereafter.
REQ-031 Fairness: req_valid=4'b1111 continuously from reset -> grants 0,1,2,3,0,... one per cycle; resp_valid follows the same order two cycles later.
REQ-032 Pipelining: only requester 1 valid, words 32'hffffffff then 32'h00000000 on consecutive cycles -> resp_valid[1] at T+2 and T+3, resp_data[63:32] = 32'h16161616 then 32'h63636363.
REQ-033 Reset mid-op: grant requester 3 at T, rst=1 at T+1 -> resp_valid=0 at T+2 and T+3, resp_data=0.
REQ-034 PRIO0=1: req_valid=4'b1001 continuously -> req_ready=4'b0001 every cycle; dropping req_valid[0] -> requester 3 granted the same cycle.

Source files
------------

// File: rtl/sbox_arbiter_if.sv
// Request/response bundle shared by four requesters and the S-box arbiter.
// Requester i owns bit i of the strobes and bits [32i+31:32i] of the data buses.
interface sbox_arbiter_if;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [127:0] resp_data;
  logic         busy;

  // Requester side: drives requests and observes grants and results.
  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_data, busy
  );

  // Arbiter side: grants requests and returns substituted words.
  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/sbox_arbiter.sv
// Four-requester round-robin arbiter (with optional strict priority for
// requester 0) feeding one shared registered 4-byte AES S-box unit.
// A granted word produces a one-cycle resp_valid pulse two cycles later.

// Registered 4-byte AES S-box: one-cycle latency, no reset.
module sbox_s4 (
  input  logic        clk,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  // Entry k sits at bits [(255-k)*8 +: 8], i.e. the table reads left to right.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - b) * 8 is just the inverted byte shifted left by three.
  function automatic logic [7:0] sbox_byte(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_reg;
      // Bytewise lookup, byte positions preserved.
      always_ff @(posedge clk) begin
        byte_reg <= sbox_byte(din[8*gi +: 8]);
      end
      assign dout[8*gi +: 8] = byte_reg;
    end
  endgenerate
endmodule

module sbox_arbiter #(
  parameter bit PRIO0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  sbox_arbiter_if.slave bus
);
  logic [1:0]  ptr_reg;
  logic [1:0]  ptr_next;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic        grant_any;
  logic        prio_hit;
  logic [1:0]  idx;
  logic [31:0] s4_in;
  logic [31:0] s4_out;
  logic        tag_valid_reg;
  logic [1:0]  tag_id_reg;
  logic [3:0]  resp_valid_reg;

  // Grant selection: optional strict priority for requester 0, else the first
  // valid requester found searching from ptr. Nothing is granted during reset.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    prio_hit  = 1'b0;
    idx       = '0;
    if (!rst) begin
      if (PRIO0 && bus.req_valid[0]) begin
        grant_any = 1'b1;
        prio_hit  = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          idx = ptr_reg + 2'(k);
          if (!grant_any && bus.req_valid[idx] && !(PRIO0 && idx == 2'd0)) begin
            grant_any = 1'b1;
            grant_id  = idx;
          end
        end
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  // Pointer advances past a round-robin winner; priority grants leave it alone.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any && !prio_hit) begin
      ptr_next = grant_id + 2'd1;
    end
  end

  // Granted word goes straight into the S-box; zero when idle so the unit
  // never sees a stale request word.
  always_comb begin
    s4_in = '0;
    if (grant_any) begin
      s4_in = bus.req_data[{grant_id, 5'b00000} +: 32];
    end
  end

  sbox_s4 u_s4 (
    .clk  (clk),
    .din  (s4_in),
    .dout (s4_out)
  );

  // Pointer and stage-1 tag follow the grant made this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= '0;
      tag_valid_reg <= 1'b0;
      tag_id_reg    <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      tag_valid_reg <= grant_any;
      tag_id_reg    <= grant_id;
    end
  end

  // Result strobe: one-hot pulse for the tagged requester, only when the tag
  // is valid so untagged S-box contents never leak out.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_reg <= '0;
    end else begin
      resp_valid_reg <= tag_valid_reg ? (4'b0001 << tag_id_reg) : 4'b0000;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_resp
      logic [31:0] slice_reg;
      // Each requester's result holds until its next result arrives.
      always_ff @(posedge clk) begin
        if (rst) begin
          slice_reg <= '0;
        end else if (tag_valid_reg && tag_id_reg == 2'(gi)) begin
          slice_reg <= s4_out;
        end
      end
      assign bus.resp_data[32*gi +: 32] = slice_reg;
    end
  endgenerate

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.busy       = tag_valid_reg;
endmodule

// File: tb/tb_sbox_arbiter.sv
// Scoreboard bench: the driver pushes expected results at grant time, monitors
// pop and compare whenever resp_valid fires.
module tb_sbox_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  localparam logic [31:0] D0 = 32'h00010253, E0 = 32'h637c77ed;
  localparam logic [31:0] D1 = 32'h10203040, E1 = 32'hcab70409;
  localparam logic [31:0] D2 = 32'h50607080, E2 = 32'h53d051cd;
  localparam logic [31:0] D3 = 32'h90a0b0c0, E3 = 32'h60e0e7ba;
  localparam logic [127:0] ALL = {D3, D2, D1, D0};

  sbox_arbiter_if bus_a ();
  sbox_arbiter_if bus_b ();

  sbox_arbiter #(.PRIO0(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sbox_arbiter #(.PRIO0(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] oh_id(input logic [3:0] oh);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // One cycle of stimulus on DUT A; records the expected result if granted.
  task automatic step_a(input logic [3:0] v, input logic [127:0] d,
                        input logic [3:0] exp_ready, input logic [31:0] exp_word,
                        input bit push);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus_a.req_valid = v;
    bus_a.req_data  = d;
    #1;
    chk("ready_a", bus_a.req_ready, exp_ready);
    $display("A cycle %0d: req_valid=%b req_ready=%b", cyc, v, bus_a.req_ready);
    if (push && exp_ready != 4'b0) begin
      e.id = oh_id(exp_ready); e.data = exp_word; e.cyc = cyc + 2;
      qa.push_back(e);
    end
  endtask

  task automatic step_b(input logic [3:0] v, input logic [127:0] d,
                        input logic [3:0] exp_ready, input logic [31:0] exp_word);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    bus_b.req_valid = v;
    bus_b.req_data  = d;
    #1;
    chk("ready_b", bus_b.req_ready, exp_ready);
    $display("B cycle %0d: req_valid=%b req_ready=%b", cyc, v, bus_b.req_ready);
    if (exp_ready != 4'b0) begin
      e.id = oh_id(exp_ready); e.data = exp_word; e.cyc = cyc + 2;
      qb.push_back(e);
    end
  endtask

  // Monitor for DUT A.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus_a.resp_valid !== 4'b0) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL resp_a_unexpected: resp_valid=%b want none (cycle %0d)", bus_a.resp_valid, cyc);
      end else begin
        e = qa.pop_front();
        chk("resp_a_valid", bus_a.resp_valid, 4'b0001 << e.id);
        chk("resp_a_data", bus_a.resp_data[32*e.id +: 32], e.data);
        chk("resp_a_cycle", cyc, e.cyc);
        $display("A resp cycle %0d: id=%0d data=%h", cyc, e.id, bus_a.resp_data[32*e.id +: 32]);
      end
    end
  end

  // Monitor for DUT B.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && bus_b.resp_valid !== 4'b0) begin
      if (qb.size() == 0) begin
        n_checks++;
        $display("FAIL resp_b_unexpected: resp_valid=%b want none (cycle %0d)", bus_b.resp_valid, cyc);
      end else begin
        e = qb.pop_front();
        chk("resp_b_valid", bus_b.resp_valid, 4'b0001 << e.id);
        chk("resp_b_data", bus_b.resp_data[32*e.id +: 32], e.data);
        chk("resp_b_cycle", cyc, e.cyc);
        $display("B resp cycle %0d: id=%0d data=%h", cyc, e.id, bus_b.resp_data[32*e.id +: 32]);
      end
    end
  end

  initial begin
    bus_a.req_valid = 4'b0; bus_a.req_data = '0;
    bus_b.req_valid = 4'b0; bus_b.req_data = '0;
    @(posedge clk);
    mon_en = 1'b1;

    // Reset held with every requester asserting.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus_a.req_valid = 4'b1111; bus_a.req_data = ALL;
      bus_b.req_valid = 4'b1111; bus_b.req_data = ALL;
      #1;
      chk("rst_ready_a", bus_a.req_ready, 4'b0);
      chk("rst_ready_b", bus_b.req_ready, 4'b0);
      chk("rst_resp_valid", bus_a.resp_valid, 4'b0);
      chk("rst_resp_data", bus_a.resp_data, 128'h0);
      chk("rst_busy", bus_a.busy, 1'b0);
      $display("reset cycle %0d checked", cyc);
    end
    bus_b.req_valid = 4'b0;

    // Fairness: all valid from the first non-reset cycle.
    for (int i = 0; i < 2; i++) begin
      step_a(4'b1111, ALL, 4'b0001, E0, 1);
      step_a(4'b1111, ALL, 4'b0010, E1, 1);
      step_a(4'b1111, ALL, 4'b0100, E2, 1);
      step_a(4'b1111, ALL, 4'b1000, E3, 1);
    end
    for (int i = 0; i < 3; i++) step_a(4'b0, '0, 4'b0, '0, 0);

    // Single transfer on requester 2.
    step_a(4'b0100, {32'h0, 32'h00010253, 64'h0}, 4'b0100, 32'h637c77ed, 1);
    step_a(4'b0, '0, 4'b0, '0, 0);
    chk("single_busy", bus_a.busy, 1'b1);
    for (int i = 0; i < 3; i++) step_a(4'b0, '0, 4'b0, '0, 0);
    chk("single_hold", bus_a.resp_data[95:64], 32'h637c77ed);
    chk("idle_busy", bus_a.busy, 1'b0);

    // Back-to-back words on requester 1.
    step_a(4'b0010, {64'h0, 32'hffffffff, 32'h0}, 4'b0010, 32'h16161616, 1);
    step_a(4'b0010, 128'h0, 4'b0010, 32'h63636363, 1);
    for (int i = 0; i < 3; i++) step_a(4'b0, '0, 4'b0, '0, 0);
    chk("pipe_hold", bus_a.resp_data[63:32], 32'h63636363);
    chk("other_hold", bus_a.resp_data[95:64], 32'h637c77ed);

    // Pointer wrap: ptr=2 picks 3, then ptr=0 picks 1.
    step_a(4'b1010, ALL, 4'b1000, E3, 1);
    step_a(4'b1010, ALL, 4'b0010, E1, 1);
    for (int i = 0; i < 3; i++) step_a(4'b0, '0, 4'b0, '0, 0);

    // Reset while a word for requester 3 is in flight.
    step_a(4'b1000, {32'hd0e0f011, 96'h0}, 4'b1000, '0, 0);
    @(negedge clk);
    rst = 1'b1;
    bus_a.req_valid = 4'b0;
    #1;
    chk("midrst_ready", bus_a.req_ready, 4'b0);
    step_a(4'b0, '0, 4'b0, '0, 0);
    chk("midrst_valid_t2", bus_a.resp_valid, 4'b0);
    chk("midrst_data", bus_a.resp_data, 128'h0);
    step_a(4'b0, '0, 4'b0, '0, 0);
    chk("midrst_valid_t3", bus_a.resp_valid, 4'b0);
    chk("midrst_busy", bus_a.busy, 1'b0);

    // Strict priority on requester 0.
    bus_a.req_valid = 4'b0;
    for (int i = 0; i < 4; i++) step_b(4'b1001, ALL, 4'b0001, E0);
    step_b(4'b1000, ALL, 4'b1000, E3);
    for (int i = 0; i < 3; i++) step_b(4'b0, '0, 4'b0, '0);

    @(negedge clk);
    chk("queue_a_empty", 128'(qa.size()), 128'h0);
    chk("queue_b_empty", 128'(qb.size()), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
